// File: rtl/mem_pkg.sv
// Shared definitions for the block-copy/fill engine: state encoding,
// command opcodes and default bus widths.
package mem_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  localparam logic OP_COPY = 1'b0;
  localparam logic OP_FILL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_addr_counter.sv
// Byte index for the engine: clear/increment register, terminal compare
// against the byte count, and the wrapping src+i / dst+i address adders.
module mem_addr_counter #(
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              inc,
  input  logic [ADDR_W-1:0] len,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  output logic [ADDR_W-1:0] idx,
  output logic [ADDR_W-1:0] src_addr,
  output logic [ADDR_W-1:0] dst_addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] idx_next;

  // Index register: cleared on command acceptance, stepped once per written byte.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (inc) begin
      idx <= idx_next;
    end
  end

  // Address arithmetic wraps at ADDR_W bits; last is true on the final byte.
  always_comb begin
    idx_next = idx + ONE;
    src_addr = src_base + idx;
    dst_addr = dst_base + idx;
    last     = (idx_next == len);
  end

endmodule

// File: rtl/mem_block_copy.sv
// Block copy / fill bus master for the 8-bit data memory. Owns the memory
// port only while busy and keeps a wrapping checksum of the bytes it wrote.
//
// Handshake: start is a single-cycle command strobe honoured only in IDLE;
// the command fields must be valid in that cycle only. busy covers the
// READ/WRITE phase, done pulses for one cycle afterwards, and the two are
// never high together. checksum is final while done is high.
module mem_block_copy
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              op,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W-1:0] len,
  input  logic [DATA_W-1:0] fill_val,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  output logic [ADDR_W-1:0] memAddress,
  output logic [DATA_W-1:0] memData,
  output logic              memWrite,
  input  logic [DATA_W-1:0] memOut,
  output state_t            state_dbg
);

  state_t state, state_n;

  logic              op_q;
  logic [ADDR_W-1:0] src_q, dst_q, len_q;
  logic [DATA_W-1:0] fill_q, data_q, sum_q;

  logic              accept;
  logic              cnt_clear, cnt_inc, cnt_last;
  logic [ADDR_W-1:0] cnt_idx, src_addr, dst_addr;
  logic [DATA_W-1:0] wr_data;

  mem_addr_counter #(.ADDR_W(ADDR_W)) u_cnt (
    .clock    (clock),
    .reset    (reset),
    .clear    (cnt_clear),
    .inc      (cnt_inc),
    .len      (len_q),
    .src_base (src_q),
    .dst_base (dst_q),
    .idx      (cnt_idx),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .last     (cnt_last)
  );

  // State register; reset aborts any command and drops memWrite at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state and memory port drive; the port is zero outside READ/WRITE.
  always_comb begin
    state_n    = state;
    accept     = 1'b0;
    cnt_clear  = 1'b0;
    cnt_inc    = 1'b0;
    memAddress = '0;
    memData    = '0;
    memWrite   = 1'b0;
    wr_data    = (op_q == OP_FILL) ? fill_q : data_q;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          cnt_clear = 1'b1;
          if (len == '0)           state_n = ST_DONE;
          else if (op == OP_FILL)  state_n = ST_WRITE;
          else                     state_n = ST_READ;
        end
      end
      ST_READ: begin
        memAddress = src_addr;
        state_n    = ST_WRITE;
      end
      ST_WRITE: begin
        memAddress = dst_addr;
        memData    = wr_data;
        memWrite   = 1'b1;
        cnt_inc    = 1'b1;
        if (cnt_last)              state_n = ST_DONE;
        else if (op_q == OP_FILL)  state_n = ST_WRITE;
        else                       state_n = ST_READ;
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Command latch, read-data register and running checksum.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q   <= OP_COPY;
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      fill_q <= '0;
      data_q <= '0;
      sum_q  <= '0;
    end else if (accept) begin
      op_q   <= op;
      src_q  <= src;
      dst_q  <= dst;
      len_q  <= len;
      fill_q <= fill_val;
      sum_q  <= '0;
    end else if (state == ST_READ) begin
      data_q <= memOut;
    end else if (state == ST_WRITE) begin
      sum_q  <= sum_q + wr_data;
    end
  end

  // Status outputs decoded straight from the state register.
  always_comb begin
    busy      = (state == ST_READ) || (state == ST_WRITE);
    done      = (state == ST_DONE);
    checksum  = sum_q;
    state_dbg = state;
  end

endmodule

// File: tb/tb_mem_block_copy.sv
// Self-checking bench for mem_block_copy paired with an 8-bit memory model.
module tb_mem_block_copy;
  import mem_pkg::*;

  logic       clock;
  logic       reset;
  logic       start;
  logic       op;
  logic [7:0] src, dst, len, fill_val;
  logic       busy, done, memWrite;
  logic [7:0] checksum, memAddress, memData, memOut;
  state_t     state_dbg;

  // memory model with a bench-side load port
  logic [7:0] mem [0:255];
  logic       ld_en;
  logic [7:0] ld_addr, ld_data;
  int         wr_count;

  int pass_count;
  int total_count;

  typedef struct {
    logic            op;
    logic [7:0]      src;
    logic [7:0]      dst;
    logic [7:0]      len;
    logic [7:0]      fill;
    int              exp_cycles;
    logic [7:0]      exp_sum;
    logic [3:0][7:0] exp_data;
  } vec_t;

  vec_t vecs [4];

  mem_block_copy dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .src        (src),
    .dst        (dst),
    .len        (len),
    .fill_val   (fill_val),
    .busy       (busy),
    .done       (done),
    .checksum   (checksum),
    .memAddress (memAddress),
    .memData    (memData),
    .memWrite   (memWrite),
    .memOut     (memOut),
    .state_dbg  (state_dbg)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign memOut = mem[memAddress];

  always @(posedge clock) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (memWrite) begin
      mem[memAddress] <= memData;
      wr_count <= wr_count + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_count++;
    if (act === exp) pass_count++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clock); #1;
    ld_en = 1'b0;
  endtask

  task automatic drive_start(input logic op_i, input logic [7:0] src_i, input logic [7:0] dst_i,
                             input logic [7:0] len_i, input logic [7:0] fill_i);
    @(posedge clock); #1;
    start = 1'b1; op = op_i; src = src_i; dst = dst_i; len = len_i; fill_val = fill_i;
    @(posedge clock); #1;
    start = 1'b0;
    // command fields only need to be valid in the start cycle
    op = 1'($urandom_range(0, 1));
    src = 8'($urandom_range(0, 255));
    dst = 8'($urandom_range(0, 255));
    len = 8'($urandom_range(0, 255));
    fill_val = 8'($urandom_range(0, 255));
  endtask

  // waits from cycle 1 after acceptance until done; counts busy&&done overlaps
  task automatic wait_done(output int cycles, output int overlap);
    cycles = 1;
    overlap = 0;
    while (!done && cycles < 600) begin
      if (busy && done) overlap++;
      @(posedge clock); #1;
      cycles++;
    end
    if (busy && done) overlap++;
  endtask

  initial begin
    int cycles, overlap, w0;
    logic [7:0] a;
    pass_count = 0; total_count = 0; wr_count = 0;
    reset = 1'b1; start = 1'b0; op = 1'b0; src = '0; dst = '0; len = '0; fill_val = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;

    for (int i = 0; i < 256; i++) poke(8'(i), 8'h00);
    poke(8'd100, 8'd10); poke(8'd101, 8'd7); poke(8'd102, 8'd75); poke(8'd103, 8'd9);
    poke(8'd254, 8'd1);  poke(8'd255, 8'd2); poke(8'd0, 8'd3);
    poke(8'd53, 8'h3C);

    // reset values
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_checksum", checksum, 0);
    check("rst_memWrite", memWrite, 0);
    check("rst_memAddress", memAddress, 0);
    check("rst_memData", memData, 0);
    check("rst_state", state_dbg, ST_IDLE);
    #2 reset = 1'b0;

    vecs[0] = '{op: OP_COPY, src: 8'd100, dst: 8'd200, len: 8'd4, fill: 8'h00,
                exp_cycles: 9, exp_sum: 8'd101, exp_data: {8'd9, 8'd75, 8'd7, 8'd10}};
    vecs[1] = '{op: OP_FILL, src: 8'd0, dst: 8'd50, len: 8'd3, fill: 8'hA5,
                exp_cycles: 4, exp_sum: 8'hEF, exp_data: {8'h00, 8'hA5, 8'hA5, 8'hA5}};
    vecs[2] = '{op: OP_COPY, src: 8'd254, dst: 8'd10, len: 8'd3, fill: 8'h00,
                exp_cycles: 7, exp_sum: 8'd6, exp_data: {8'h00, 8'd3, 8'd2, 8'd1}};
    vecs[3] = '{op: OP_COPY, src: 8'd100, dst: 8'd20, len: 8'd0, fill: 8'h00,
                exp_cycles: 1, exp_sum: 8'd0, exp_data: {8'h00, 8'h00, 8'h00, 8'h00}};

    for (int v = 0; v < 4; v++) begin
      w0 = wr_count;
      drive_start(vecs[v].op, vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].fill);
      wait_done(cycles, overlap);
      check($sformatf("v%0d_done_cycle", v), cycles, vecs[v].exp_cycles);
      check($sformatf("v%0d_busy_done_overlap", v), overlap, 0);
      check($sformatf("v%0d_checksum", v), checksum, vecs[v].exp_sum);
      check($sformatf("v%0d_write_count", v), wr_count - w0, vecs[v].len);
      for (int k = 0; k < 4; k++) begin
        if (k < int'(vecs[v].len)) begin
          a = vecs[v].dst + 8'(k);
          check($sformatf("v%0d_mem_%0d", v, a), mem[a], vecs[v].exp_data[k]);
        end
      end
      @(posedge clock); #1;
      check($sformatf("v%0d_done_pulse_width", v), done, 0);
      check($sformatf("v%0d_checksum_held", v), checksum, vecs[v].exp_sum);
    end
    check("fill_mem_53_untouched", mem[53], 8'h3C);

    // reset during WRITE of byte 2 of a 4-byte COPY
    w0 = wr_count;
    drive_start(OP_COPY, 8'd200, 8'd150, 8'd4, 8'h00);
    repeat (3) @(posedge clock);
    #1;
    check("abort_in_write", memWrite, 1);
    check("abort_addr", memAddress, 8'd151);
    #2 reset = 1'b1;
    #1;
    check("abort_memWrite", memWrite, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_checksum", checksum, 0);
    check("abort_memAddress", memAddress, 0);
    check("abort_memData", memData, 0);
    check("abort_state", state_dbg, ST_IDLE);
    @(posedge clock); #2;
    reset = 1'b0;
    check("abort_byte1", mem[150], 8'd10);
    check("abort_byte2_unwritten", mem[151], 8'd0);
    check("abort_write_count", wr_count - w0, 1);

    // forward overlapping COPY with a stray start while busy
    w0 = wr_count;
    drive_start(OP_COPY, 8'd100, 8'd101, 8'd3, 8'h00);
    cycles = 1;
    overlap = 0;
    start = 1'b1; op = OP_FILL; dst = 8'd0; len = 8'd5; fill_val = 8'hFF;
    @(posedge clock); #1;
    cycles++;
    start = 1'b0;
    while (!done && cycles < 600) begin
      if (busy && done) overlap++;
      @(posedge clock); #1;
      cycles++;
    end
    check("ovl_done_cycle", cycles, 7);
    check("ovl_busy_done_overlap", overlap, 0);
    check("ovl_checksum", checksum, 8'd30);
    check("ovl_mem_101", mem[101], 8'd10);
    check("ovl_mem_102", mem[102], 8'd10);
    check("ovl_mem_103", mem[103], 8'd10);
    repeat (3) @(posedge clock);
    #1;
    check("ovl_idle_after", busy, 0);
    check("ovl_write_count", wr_count - w0, 3);
    check("ovl_stray_fill_ignored", mem[0], 8'd3);

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule

// File: doc/mem_block_copy.md
# mem_block_copy

Bus-master engine for the 8-bit data memory: it drives address, write data and the write strobe, and reads back through the memory's combinational read port. On a start command it copies a block of bytes from a source region to a destination region, or fills a region with a constant. It sits beside the datapath and owns the memory port only while busy. It also reports an 8-bit running checksum of the bytes it wrote.

## Interface
Parameters:
- ADDR_W, 8, memory address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 8, memory word width.

Ports:
- clock  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- op  in  1  command: 0 = COPY, 1 = FILL.
- src  in  ADDR_W  COPY source base address; ignored for FILL.
- dst  in  ADDR_W  destination base address.
- len  in  ADDR_W  byte count, 0..255.
- fill_val  in  DATA_W  FILL constant.
- busy  out  1  high from the cycle after start is accepted until DONE is entered.
- done  out  1  one-cycle pulse at command completion.
- checksum  out  DATA_W  mod-256 sum of all bytes written by the last command; held until the next accepted start.
- memAddress  out  ADDR_W  memory address.
- memData  out  DATA_W  memory write data.
- memWrite  out  1  memory write strobe; the memory writes on the rising edge while it is high.
- memOut  in  DATA_W  memory read data, combinational from memAddress.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE, start=1: latch op, src, dst, len and fill_val; clear the index i and checksum.
  - len=0: go to DONE.
  - COPY: go to READ.
  - FILL: go to WRITE.
- READ: memAddress=src+i, memWrite=0; at the clock edge, latch memOut into the data register and go to WRITE.
- WRITE: memAddress=dst+i, memData=data register (COPY) or fill_val (FILL), memWrite=1.
  - At the edge, checksum += memData and i += 1.
  - If i+1 == len, go to DONE; otherwise go to READ (COPY) or stay in WRITE (FILL).
- DONE: done=1 for one cycle, then return to IDLE.
- All address arithmetic is ADDR_W bits and wraps: 255+1 = 0. Checksum is DATA_W bits and wraps.
- Overlapping COPY is strictly forward, byte by byte. With dst = src+1, the first byte therefore propagates through the whole region; this is the defined behaviour.
- start while busy or in DONE is ignored. Command inputs need to be valid only in the start cycle.
- In IDLE and DONE: memWrite=0, memAddress=0, memData=0.

## Timing
- Reset values: busy=0, done=0, checksum=0, memWrite=0, memAddress=0, memData=0; state=IDLE.
- Reset asserted mid-command aborts immediately. memWrite drops asynchronously and no further writes occur. A write in flight at the edge coincident with reset is not performed.
- COPY of len=N: busy for 2N cycles, then done in cycle 2N+1 after acceptance.
- FILL of len=N: busy for N cycles, then done in cycle N+1.
- len=0: done in the cycle after acceptance, with no memory access.
- busy and done are never high together. checksum is final when done is high.

## Structure
- Shared package (mem_pkg):
  - state encoding (IDLE/READ/WRITE/DONE)
  - op constants OP_COPY=1'b0, OP_FILL=1'b1
  - ADDR_W/DATA_W defaults
- One sub-module, mem_addr_counter: index register with clear/increment, terminal compare against len, and base+index adders for both the src and dst addresses.
- The bench pairs this block with the existing 8-bit data memory model.

## Test plan
- Preload mem[100..103]=10,7,75,9; COPY src=100, dst=200, len=4 -> mem[200..203]=10,7,75,9; done in cycle 9; checksum=101.
- FILL dst=50, len=3, fill_val=8'hA5 -> mem[50..52]=A5; mem[53] unchanged; done in cycle 4; checksum=8'hEF.
- COPY src=254, dst=10, len=3 with mem[254]=1, mem[255]=2, mem[0]=3 -> mem[10..12]=1,2,3 (address wrap).
- COPY len=0 -> memWrite never asserted; done one cycle after start; checksum=0.
- COPY src=100, dst=101, len=3 with mem[100]=10 -> mem[101..103]=10,10,10 (forward overlap); a second start pulse during busy is ignored.
- Reset asserted during the WRITE state of byte 2 of a 4-byte COPY -> memWrite low immediately; only byte 1 written; all outputs at reset values; a new command afterwards completes normally.
